ram_to_stream: RTL and testbench
================================

# ram_to_stream

Readback stage that sits directly downstream of the capture-to-RAM writer. Once a bank has been filled, this block reads captured data blocks back out of that RAM bank with AXI4 INCR read bursts and presents them, in address order, as an AXI-Stream. Bursts are one RAM block each. Read requests are credit-limited against an internal FIFO, so R-channel data is never back-pressured.

## Interface

**Parameters**
- DW, 512: data width in bits (AXI RDATA and stream TDATA).
- BASE_ADDR, 64'h0: byte address of block 0 of the bank being read.
- CYCLES_PER_BLOCK, 32: beats per RAM block and per burst. Range 1..256.
- MAX_BLOCKS, 65536: capacity of the bank in blocks. Requests are clamped to this.
- FIFO_DEPTH, 256: output FIFO depth in beats. Must be ≥ CYCLES_PER_BLOCK.
- MAX_OUTSTANDING, 4: maximum AR bursts issued but not yet fully received.

**Ports**
- clk, in, 1: single clock.
- sys_reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to begin readback.
- block_count, in, 32: number of blocks to read. Sampled on the accepted start.
- busy, out, 1: readback in progress.
- done, out, 1: one-cycle pulse when the final beat has left AXIS_OUT.
- blocks_read, out, 32: number of bursts fully received on R.
- rd_error, out, 1: sticky flag. Set by any RRESP ≠ 0.
- M_AXI_ARADDR, out, 64: burst address.
- M_AXI_ARLEN, out, 8: constant CYCLES_PER_BLOCK-1.
- M_AXI_ARSIZE, out, 3: constant $clog2(DW/8).
- M_AXI_ARBURST, out, 2: constant 1 (INCR).
- M_AXI_ARID, out, 4: constant 0.
- M_AXI_ARLOCK, out, 1: constant 0.
- M_AXI_ARCACHE, out, 4: constant 0.
- M_AXI_ARQOS, out, 4: constant 0.
- M_AXI_ARPROT, out, 3: constant 0.
- M_AXI_ARVALID, out, 1.
- M_AXI_ARREADY, in, 1.
- M_AXI_RDATA, in, DW.
- M_AXI_RVALID, in, 1.
- M_AXI_RRESP, in, 2.
- M_AXI_RLAST, in, 1.
- M_AXI_RREADY, out, 1: equals ~sys_reset.
- AXIS_OUT_TDATA, out, DW.
- AXIS_OUT_TVALID, out, 1.
- AXIS_OUT_TLAST, out, 1: asserted only on the final beat of the final block.
- AXIS_OUT_TREADY, in, 1.

## Operation

**Request handling**
- BLOCK_BYTES = CYCLES_PER_BLOCK·DW/8.
- On start in IDLE, latch target = min(block_count, MAX_BLOCKS), clear blocks_read, and set ARADDR to BASE_ADDR.
- start while busy is ignored.

**State machine: IDLE → RUN → DRAIN → IDLE**
- IDLE: busy = 0. An accepted start moves to RUN.
  - If target = 0, the block goes straight to DRAIN, issues no AR, and pulses done with TLAST never asserted.
- RUN: issue bursts.
  - ARVALID rises when ar_issued < target, outstanding < MAX_OUTSTANDING, and reserved + CYCLES_PER_BLOCK ≤ FIFO_DEPTH.
  - Once ARVALID is raised, it and ARADDR hold stable until ARREADY.
  - On the AR handshake: ar_issued++, ARADDR += BLOCK_BYTES, outstanding++, reserved += CYCLES_PER_BLOCK.
  - When ar_issued = target and ARVALID = 0, move to DRAIN.
- DRAIN: wait until outstanding = 0 and the FIFO is empty after the final beat is accepted. Then pulse done for 1 cycle and return to IDLE.

**R channel**
- Every R beat is written to the FIFO. The credit scheme guarantees space.
- On RLAST: outstanding--, blocks_read++.
- A non-zero RRESP sets rd_error. The data is still forwarded.

**Credit accounting**
- reserved = FIFO occupancy plus requested-but-unreceived beats.
- reserved decrements by 1 on each AXIS_OUT handshake.
- A simultaneous AR handshake and AXIS_OUT handshake nets reserved += CYCLES_PER_BLOCK-1.
- A simultaneous AR handshake and RLAST nets outstanding unchanged.

**Stream output**
- AXIS_OUT carries FIFO data in order.
- TLAST is asserted on the beat where out_beats = target·CYCLES_PER_BLOCK.

**Width rules**
- ARADDR is 64-bit and wraps modulo 2^64. No bank boundary check is made beyond MAX_BLOCKS.
- Beat counter is 40 bits.

**Reset**
- Reset mid-operation aborts immediately and flushes the FIFO.
- Reset values: busy 0, done 0, blocks_read 0, rd_error 0, ARVALID 0, ARADDR BASE_ADDR, TVALID 0, TLAST 0, RREADY 0.
- The integrator must reset the interconnect together with this block. In-flight R beats after reset are not tracked.

## Timing

- start at cycle T → busy = 1 at T+1 → earliest ARVALID at T+2.
- R beat accepted at cycle N → earliest TVALID for that beat at N+2 (FIFO latency).
- Back-to-back AR issue is allowed: 1 burst per cycle while credits permit.
- Sustained throughput is 1 beat/clk when TREADY = 1 and RVALID streams.
- done is asserted the cycle after the final AXIS_OUT handshake, coincident with busy falling.

## Test plan

1. **Single block, ideal slave.** block_count = 1, CYCLES_PER_BLOCK = 32, zero-wait slave, TREADY = 1 → exactly one AR with ARADDR = BASE_ADDR and ARLEN = 31; 32 ordered beats out; TLAST on beat 32; done 1 cycle later; blocks_read = 1.
2. **Multi-block address stepping.** block_count = 10, DW = 512 → ARADDRs BASE_ADDR + k·2048 for k = 0..9; 320 beats out in address order; exactly one TLAST.
3. **Back-pressure / credit limit.** TREADY held 0, FIFO_DEPTH = 256 → at most 8 AR handshakes and never more than 4 outstanding. RREADY never drops; no data loss once TREADY = 1.
4. **Clamp and zero.** block_count = 70000 → 65536 bursts issued. block_count = 0 → no ARVALID, done at T+2. start while busy → ignored.
5. **Error response.** RRESP = 2 on one beat → rd_error = 1 and stays set; data still streams; done still pulses.
6. **Reset mid-run.** sys_reset asserted after 3 of 10 bursts → next cycle all outputs at reset values and FIFO empty. A fresh start then re-reads from BASE_ADDR.

Source files
------------

// File: rtl/ram_to_stream.sv
// Small synchronous FIFO whose head sits in an output register.
// Latency: a word written in cycle N is valid on out_vld in cycle N+2.
// Backpressure: out_rdy stalls the head; no in_rdy, so the writer must guarantee free space.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;

    assign pop = (count != '0) && (!out_vld || out_rdy);

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (in_vld) mem[wr_ptr] <= in_dat;
        if (pop)    out_dat     <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_vld <= 1'b0;
        end else begin
            if (in_vld) wr_ptr <= bump(wr_ptr);
            if (pop)    rd_ptr <= bump(rd_ptr);
            case ({in_vld, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (pop)          out_vld <= 1'b1;
            else if (out_rdy) out_vld <= 1'b0;
        end
    end
endmodule

// Reads a captured RAM bank back with one-block AXI4 INCR bursts and streams it out in order.
// Latency: start->ARVALID 2 cycles; R beat->TVALID 2 cycles; 1 beat/clk sustained.
// Backpressure: TREADY stalls the FIFO; AR issue is credit-limited so RREADY never drops.
module ram_to_stream #(
    parameter int          DW               = 512,
    parameter logic [63:0] BASE_ADDR        = 64'h0,
    parameter int          CYCLES_PER_BLOCK = 32,
    parameter int          MAX_BLOCKS       = 65536,
    parameter int          FIFO_DEPTH       = 256,
    parameter int          MAX_OUTSTANDING  = 4
) (
    input  logic          clk,
    input  logic          sys_reset,
    input  logic          start,
    input  logic [31:0]   block_count,
    output logic          busy,
    output logic          done,
    output logic [31:0]   blocks_read,
    output logic          rd_error,
    output logic [63:0]   M_AXI_ARADDR,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic [3:0]    M_AXI_ARID,
    output logic          M_AXI_ARLOCK,
    output logic [3:0]    M_AXI_ARCACHE,
    output logic [3:0]    M_AXI_ARQOS,
    output logic [2:0]    M_AXI_ARPROT,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic          M_AXI_RVALID,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RLAST,
    output logic          M_AXI_RREADY,
    output logic [DW-1:0] AXIS_OUT_TDATA,
    output logic          AXIS_OUT_TVALID,
    output logic          AXIS_OUT_TLAST,
    input  logic          AXIS_OUT_TREADY
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;

    localparam logic [63:0] BLOCK_BYTES = 64'(CYCLES_PER_BLOCK * (DW / 8));
    localparam logic [31:0] CPB         = 32'(CYCLES_PER_BLOCK);
    localparam logic [31:0] DEPTH       = 32'(FIFO_DEPTH);
    localparam logic [31:0] MAX_OUT     = 32'(MAX_OUTSTANDING);
    localparam logic [31:0] MAX_BLK     = 32'(MAX_BLOCKS);

    logic [1:0]  state;
    logic [31:0] target;
    logic [31:0] ar_issued;
    logic [31:0] outstanding;
    logic [31:0] reserved;
    logic [39:0] total_beats;
    logic [39:0] out_beats;

    logic        ar_hs;
    logic        r_hs;
    logic        r_last_hs;
    logic        out_hs;
    logic [31:0] issued_nxt;
    logic [31:0] outstanding_nxt;
    logic [31:0] reserved_nxt;
    logic [31:0] start_target;
    logic        can_issue;
    logic        drain_done;

    assign M_AXI_ARLEN   = 8'(CYCLES_PER_BLOCK - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_RREADY  = ~sys_reset;

    assign busy      = (state != S_IDLE);
    assign ar_hs     = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs      = M_AXI_RVALID & M_AXI_RREADY;
    assign r_last_hs = r_hs & M_AXI_RLAST;
    assign out_hs    = AXIS_OUT_TVALID & AXIS_OUT_TREADY;

    // Issue decisions look at next-cycle counters so bursts can go out back to back.
    always_comb begin
        issued_nxt      = ar_issued + {31'd0, ar_hs};
        outstanding_nxt = outstanding + {31'd0, ar_hs} - {31'd0, r_last_hs};
        reserved_nxt    = reserved + (ar_hs ? CPB : 32'd0) - {31'd0, out_hs};
        can_issue       = (issued_nxt < target) && (outstanding_nxt < MAX_OUT) &&
                          (reserved_nxt + CPB <= DEPTH);
        start_target    = (block_count > MAX_BLK) ? MAX_BLK : block_count;
        drain_done      = (outstanding == 32'd0) &&
                          ((reserved == 32'd0) || ((reserved == 32'd1) && out_hs));
    end

    assign AXIS_OUT_TLAST = AXIS_OUT_TVALID && (state != S_IDLE) &&
                            (out_beats + 40'd1 == total_beats);

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state         <= S_IDLE;
            target        <= '0;
            ar_issued     <= '0;
            outstanding   <= '0;
            reserved      <= '0;
            total_beats   <= '0;
            out_beats     <= '0;
            done          <= 1'b0;
            blocks_read   <= '0;
            rd_error      <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= BASE_ADDR;
        end else begin
            done        <= 1'b0;
            outstanding <= outstanding_nxt;
            reserved    <= reserved_nxt;
            if (r_last_hs)                      blocks_read <= blocks_read + 32'd1;
            if (r_hs && (M_AXI_RRESP != 2'b00)) rd_error    <= 1'b1;
            if (out_hs)                         out_beats   <= out_beats + 40'd1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        target       <= start_target;
                        total_beats  <= 40'(start_target) * 40'(CPB);
                        blocks_read  <= '0;
                        ar_issued    <= '0;
                        out_beats    <= '0;
                        M_AXI_ARADDR <= BASE_ADDR;
                        state        <= (start_target == 32'd0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    ar_issued     <= issued_nxt;
                    if (ar_hs) M_AXI_ARADDR <= M_AXI_ARADDR + BLOCK_BYTES;
                    M_AXI_ARVALID <= (M_AXI_ARVALID & ~M_AXI_ARREADY) | can_issue;
                    if ((ar_issued == target) && !M_AXI_ARVALID) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (sys_reset),
        .in_vld  (r_hs),
        .in_dat  (M_AXI_RDATA),
        .out_vld (AXIS_OUT_TVALID),
        .out_dat (AXIS_OUT_TDATA),
        .out_rdy (AXIS_OUT_TREADY)
    );
endmodule

// File: tb/tb_ram_to_stream.sv
// Directed bench for ram_to_stream with a scripted AXI read slave and stream sink.
module tb_ram_to_stream;
    localparam int          DW   = 64;
    localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
    localparam int          CPB  = 4;
    localparam int          MAXB = 16;
    localparam int          FD   = 32;
    localparam int          MO   = 4;
    localparam logic [63:0] BB   = 64'(CPB * DW / 8);

    logic          clk = 1'b0;
    logic          sys_reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   block_count = '0;
    logic          busy, done, rd_error;
    logic [31:0]   blocks_read;
    logic [63:0]   M_AXI_ARADDR;
    logic [7:0]    M_AXI_ARLEN;
    logic [2:0]    M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0]    M_AXI_ARBURST;
    logic [3:0]    M_AXI_ARID, M_AXI_ARCACHE, M_AXI_ARQOS;
    logic          M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic          M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;
    logic [1:0]    M_AXI_RRESP;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic          AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TREADY;

    ram_to_stream #(
        .DW(DW), .BASE_ADDR(BASE), .CYCLES_PER_BLOCK(CPB), .MAX_BLOCKS(MAXB),
        .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .sys_reset(sys_reset), .start(start), .block_count(block_count),
        .busy(busy), .done(done), .blocks_read(blocks_read), .rd_error(rd_error),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY),
        .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
        .AXIS_OUT_TLAST(AXIS_OUT_TLAST), .AXIS_OUT_TREADY(AXIS_OUT_TREADY)
    );

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int tready_mode = 1;
    int ar_mode = 0;
    int err_beat = -1;
    int r_run_cnt = 0;
    logic [63:0] ar_pend[$];
    logic [63:0] ar_log[$];
    logic [63:0] out_q[$];
    int          tlast_q[$];
    int done_cnt = 0, done_cyc = -1, first_arv = -1, first_tv = -1, first_r = -1;
    int last_hs_cyc = -1, max_out = 0, out_tb = 0, ar_unstable = 0, rready_drop = 0;
    int start_cyc = 0;
    logic [63:0] cur_addr = '0;
    logic [63:0] prev_addr = '0;
    int beat = 0;
    bit burst_active = 1'b0, prev_arv = 1'b0, prev_hs = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave and sink: inputs change half a cycle away from the sampling edge.
    initial begin
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
        M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0; AXIS_OUT_TREADY = 1'b0;
        forever begin
            @(negedge clk); #1;
            case (tready_mode)
                0:       AXIS_OUT_TREADY = 1'b0;
                1:       AXIS_OUT_TREADY = 1'b1;
                default: AXIS_OUT_TREADY = ($urandom_range(0, 3) != 0);
            endcase
            M_AXI_ARREADY = (ar_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
            if (!sys_reset && prev_arv && !prev_hs &&
                (!M_AXI_ARVALID || M_AXI_ARADDR !== prev_addr)) ar_unstable++;
            if (!sys_reset && !M_AXI_RREADY) rready_drop++;
            if (M_AXI_ARVALID && first_arv < 0) first_arv = cyc;
            if (AXIS_OUT_TVALID && first_tv < 0) first_tv = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!sys_reset && AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                if (AXIS_OUT_TLAST) tlast_q.push_back(out_q.size());
                out_q.push_back(AXIS_OUT_TDATA);
                last_hs_cyc = cyc;
            end
            if (sys_reset) begin
                ar_pend.delete();
                burst_active = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
                out_tb = 0; prev_arv = 1'b0; prev_hs = 1'b0;
            end else begin
                if (!burst_active && ar_pend.size() > 0) begin
                    cur_addr = ar_pend.pop_front(); beat = 0; burst_active = 1'b1;
                end
                if (burst_active) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA  = cur_addr + 64'(beat) * 64'd8;
                    M_AXI_RLAST  = (beat == CPB - 1);
                    M_AXI_RRESP  = (r_run_cnt == err_beat) ? 2'b10 : 2'b00;
                    if (M_AXI_RREADY) begin
                        if (first_r < 0) first_r = cyc;
                        r_run_cnt++;
                        beat++;
                        if (M_AXI_RLAST) begin burst_active = 1'b0; out_tb--; end
                    end
                end else begin
                    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
                end
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    ar_pend.push_back(M_AXI_ARADDR);
                    ar_log.push_back(M_AXI_ARADDR);
                    out_tb++;
                end
                if (out_tb > max_out) max_out = out_tb;
                prev_arv = M_AXI_ARVALID;
                prev_hs = M_AXI_ARVALID && M_AXI_ARREADY;
                prev_addr = M_AXI_ARADDR;
            end
        end
    end

    task automatic clear_log();
        ar_log.delete(); out_q.delete(); tlast_q.delete();
        done_cnt = 0; done_cyc = -1; first_arv = -1; first_tv = -1; first_r = -1;
        last_hs_cyc = -1; max_out = 0; ar_unstable = 0; rready_drop = 0; r_run_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] n);
        block_count = n; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
        timed_out = (done_cnt == 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, rd_error, M_AXI_ARVALID, AXIS_OUT_TVALID, AXIS_OUT_TLAST, M_AXI_RREADY} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/err/arv/tv/tl/rr=%b want 0000000",
                     {busy, done, rd_error, M_AXI_ARVALID, AXIS_OUT_TVALID, AXIS_OUT_TLAST, M_AXI_RREADY});
        end
        checks++;
        if (blocks_read !== 32'd0 || M_AXI_ARADDR !== BASE) begin
            errors++;
            $display("FAIL reset_regs: got blocks_read=%0d araddr=%h want 0 %h", blocks_read, M_AXI_ARADDR, BASE);
        end
        sys_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (M_AXI_RREADY !== 1'b1) begin
            errors++; $display("FAIL rready_after_reset: got %b want 1", M_AXI_RREADY);
        end
        checks++;
        if (M_AXI_ARLEN !== 8'd3 || M_AXI_ARSIZE !== 3'd3 || M_AXI_ARBURST !== 2'b01) begin
            errors++;
            $display("FAIL ar_constants: got len=%0d size=%0d burst=%0d want 3 3 1", M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST);
        end
    endtask

    task automatic test_single();
        bit to;
        int bad = 0;
        tready_mode = 1; ar_mode = 0; clear_log();
        do_start(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t1: got %b want 1", busy); end
        wait_done(200, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout: got no done want done"); end
        checks++;
        if (ar_log.size() != 1 || ar_log[0] !== BASE) begin
            errors++; $display("FAIL single_ar: got count=%0d want 1 at %h", ar_log.size(), BASE);
        end
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== BASE + 64'(i) * 64'd8) bad++;
        checks++;
        if (out_q.size() != 4 || bad != 0) begin
            errors++; $display("FAIL single_data: got beats=%0d bad=%0d want 4 0", out_q.size(), bad);
        end
        checks++;
        if (tlast_q.size() != 1 || tlast_q[0] != 3) begin
            errors++; $display("FAIL single_tlast: got count=%0d want 1 on beat 3", tlast_q.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            errors++; $display("FAIL single_done: got pulses=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_hs_cyc + 1);
        end
        checks++;
        if (first_arv != start_cyc + 2) begin
            errors++; $display("FAIL single_ar_latency: got cycle %0d want %0d", first_arv, start_cyc + 2);
        end
        checks++;
        if (first_tv != first_r + 2) begin
            errors++; $display("FAIL single_fifo_latency: got cycle %0d want %0d", first_tv, first_r + 2);
        end
        checks++;
        if (blocks_read !== 32'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_status: got blocks_read=%0d busy=%b want 1 0", blocks_read, busy);
        end
    endtask

    task automatic test_multi();
        bit to;
        int bad_a = 0, bad_d = 0;
        tready_mode = 2; ar_mode = 1; clear_log();
        do_start(10);
        wait_done(600, to);
        checks++;
        if (to) begin errors++; $display("FAIL multi_timeout: got no done want done"); end
        for (int k = 0; k < ar_log.size(); k++) if (ar_log[k] !== BASE + 64'(k) * BB) bad_a++;
        checks++;
        if (ar_log.size() != 10 || bad_a != 0) begin
            errors++; $display("FAIL multi_addr: got count=%0d bad=%0d want 10 0", ar_log.size(), bad_a);
        end
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== BASE + 64'(i) * 64'd8) bad_d++;
        checks++;
        if (out_q.size() != 40 || bad_d != 0) begin
            errors++; $display("FAIL multi_data: got beats=%0d bad=%0d want 40 0", out_q.size(), bad_d);
        end
        checks++;
        if (tlast_q.size() != 1 || tlast_q[0] != 39) begin
            errors++; $display("FAIL multi_tlast: got count=%0d want 1 on beat 39", tlast_q.size());
        end
        checks++;
        if (ar_unstable != 0) begin errors++; $display("FAIL multi_ar_hold: got %0d changes want 0", ar_unstable); end
        checks++;
        if (blocks_read !== 32'd10 || done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL multi_done: got blocks=%0d pulses=%0d at %0d want 10 1 at %0d", blocks_read, done_cnt, done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_credit();
        bit to;
        int bad = 0;
        tready_mode = 0; ar_mode = 0; clear_log();
        do_start(10);
        repeat (150) @(negedge clk);
        checks++;
        if (ar_log.size() != 8) begin errors++; $display("FAIL credit_ar_count: got %0d want 8", ar_log.size()); end
        checks++;
        if (max_out != 4) begin errors++; $display("FAIL credit_outstanding: got max %0d want 4", max_out); end
        checks++;
        if (blocks_read !== 32'd8 || AXIS_OUT_TVALID !== 1'b1) begin
            errors++; $display("FAIL credit_held: got blocks=%0d tvalid=%b want 8 1", blocks_read, AXIS_OUT_TVALID);
        end
        tready_mode = 1;
        wait_done(400, to);
        checks++;
        if (to) begin errors++; $display("FAIL credit_timeout: got no done want done"); end
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== BASE + 64'(i) * 64'd8) bad++;
        checks++;
        if (out_q.size() != 40 || bad != 0 || ar_log.size() != 10) begin
            errors++; $display("FAIL credit_data: got beats=%0d bad=%0d ars=%0d want 40 0 10", out_q.size(), bad, ar_log.size());
        end
        checks++;
        if (rready_drop != 0 || tlast_q.size() != 1) begin
            errors++; $display("FAIL credit_rready_tlast: got drops=%0d tlasts=%0d want 0 1", rready_drop, tlast_q.size());
        end
    endtask

    task automatic test_clamp_zero();
        bit to;
        int bad = 0;
        tready_mode = 1; ar_mode = 0; clear_log();
        do_start(20);
        repeat (10) @(negedge clk);
        block_count = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(800, to);
        checks++;
        if (to) begin errors++; $display("FAIL clamp_timeout: got no done want done"); end
        for (int k = 0; k < ar_log.size(); k++) if (ar_log[k] !== BASE + 64'(k) * BB) bad++;
        checks++;
        if (ar_log.size() != 16 || bad != 0) begin
            errors++; $display("FAIL clamp_ar: got count=%0d bad=%0d want 16 0", ar_log.size(), bad);
        end
        checks++;
        if (out_q.size() != 64 || tlast_q.size() != 1 || tlast_q[0] != 63 || blocks_read !== 32'd16) begin
            errors++; $display("FAIL clamp_stream: got beats=%0d tlasts=%0d blocks=%0d want 64 1 16", out_q.size(), tlast_q.size(), blocks_read);
        end
        clear_log();
        do_start(0);
        wait_done(20, to);
        checks++;
        if (to || done_cyc != start_cyc + 2) begin
            errors++; $display("FAIL zero_done: got cycle %0d want %0d", done_cyc, start_cyc + 2);
        end
        checks++;
        if (first_arv != -1 || tlast_q.size() != 0 || out_q.size() != 0 || blocks_read !== 32'd0) begin
            errors++;
            $display("FAIL zero_quiet: got arv_cycle=%0d tlasts=%0d beats=%0d blocks=%0d want -1 0 0 0", first_arv, tlast_q.size(), out_q.size(), blocks_read);
        end
    endtask

    task automatic test_error();
        bit to;
        int bad = 0;
        tready_mode = 1; ar_mode = 0; clear_log();
        checks++;
        if (rd_error !== 1'b0) begin errors++; $display("FAIL error_pre: got %b want 0", rd_error); end
        err_beat = 5;
        do_start(2);
        wait_done(200, to);
        checks++;
        if (to || done_cnt != 1) begin errors++; $display("FAIL error_done: got pulses=%0d want 1", done_cnt); end
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== BASE + 64'(i) * 64'd8) bad++;
        checks++;
        if (rd_error !== 1'b1 || out_q.size() != 8 || bad != 0) begin
            errors++; $display("FAIL error_flag_data: got err=%b beats=%0d bad=%0d want 1 8 0", rd_error, out_q.size(), bad);
        end
        err_beat = -1; clear_log();
        do_start(1);
        wait_done(200, to);
        checks++;
        if (to || rd_error !== 1'b1 || blocks_read !== 32'd1) begin
            errors++; $display("FAIL error_sticky: got err=%b blocks=%0d want 1 1", rd_error, blocks_read);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0, tv_seen = 0, bad = 0;
        tready_mode = 2; ar_mode = 0; clear_log();
        do_start(10);
        while (blocks_read < 32'd3 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (blocks_read < 32'd3) begin errors++; $display("FAIL midreset_progress: got blocks=%0d want >=3", blocks_read); end
        sys_reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, rd_error, M_AXI_ARVALID, AXIS_OUT_TVALID, AXIS_OUT_TLAST, M_AXI_RREADY} !== 7'b0 ||
            blocks_read !== 32'd0 || M_AXI_ARADDR !== BASE) begin
            errors++;
            $display("FAIL midreset_outputs: got flags=%b blocks=%0d araddr=%h want 0000000 0 %h",
                     {busy, done, rd_error, M_AXI_ARVALID, AXIS_OUT_TVALID, AXIS_OUT_TLAST, M_AXI_RREADY}, blocks_read, M_AXI_ARADDR, BASE);
        end
        sys_reset = 1'b0;
        repeat (5) begin @(negedge clk); if (AXIS_OUT_TVALID !== 1'b0) tv_seen++; end
        checks++;
        if (tv_seen != 0) begin errors++; $display("FAIL midreset_fifo_empty: got %0d valid cycles want 0", tv_seen); end
        tready_mode = 1; clear_log();
        do_start(2);
        wait_done(200, to);
        for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== BASE + 64'(i) * 64'd8) bad++;
        checks++;
        if (to || ar_log.size() != 2 || ar_log[0] !== BASE || out_q.size() != 8 || bad != 0) begin
            errors++; $display("FAIL midreset_restart: got ars=%0d beats=%0d bad=%0d want 2 8 0", ar_log.size(), out_q.size(), bad);
        end
        checks++;
        if (tlast_q.size() != 1 || tlast_q[0] != 7) begin
            errors++; $display("FAIL midreset_tlast: got count=%0d want 1 on beat 7", tlast_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_credit();
        test_clamp_zero();
        test_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
